tdc_capture_ctrl: RTL



---
 rtl/tdc_capture_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tdc_capture_ctrl.sv
// tdc_capture_ctrl: TDC measurement sequencer and thermometer-to-binary fine encoder.
// Detects start/stop edges, counts whole cycles between them, captures the tap
// code at stop and delivers {coarse, fine, overflow} over a valid/ready handshake.
// Optional feature macro: TDC_BUBBLE_FIX_EN (3-tap majority filter before encoding).
module tdc_capture_ctrl #(
  parameter int unsigned TAPS     = 32,
  parameter int unsigned COARSE_W = 8,
  parameter int unsigned FINE_W   = $clog2(TAPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [TAPS-1:0]     therm_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [COARSE_W-1:0] res_coarse_o,
  output logic [FINE_W-1:0]   res_fine_o,
  output logic                res_ovf_o,
  output logic                busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] ENCODE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

  logic [1:0]          state_q, state_d;
  logic                start_q, stop_q;
  logic                start_edge_c, stop_edge_c;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [TAPS-1:0]     therm_q, therm_d;
  logic                res_valid_q, res_valid_d;
  logic [COARSE_W-1:0] res_coarse_q, res_coarse_d;
  logic [FINE_W-1:0]   res_fine_q, res_fine_d;
  logic                res_ovf_q, res_ovf_d;
  logic                busy_q, busy_d;
  logic [TAPS-1:0]     code_c;
  logic [FINE_W-1:0]   fine_c;
  logic                zero_found_c;

  assign start_edge_c = start_i & ~start_q;
  assign stop_edge_c  = stop_i & ~stop_q;

`ifdef TDC_BUBBLE_FIX_EN
  // Pad with a virtual 1 below tap 0 and a virtual 0 above the top tap.
  logic [TAPS+1:0] therm_ext_c;
  assign therm_ext_c = {1'b0, therm_q, 1'b1};

  // Majority of each tap and its two neighbours removes single-tap bubbles.
  always_comb begin
    code_c = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      code_c[i] = (therm_ext_c[i] & therm_ext_c[i+1]) |
                  (therm_ext_c[i] & therm_ext_c[i+2]) |
                  (therm_ext_c[i+1] & therm_ext_c[i+2]);
    end
  end
`else
  assign code_c = therm_q;
`endif

  // Fine value is the position of the first zero, TAPS when the code is all ones.
  always_comb begin
    fine_c       = FINE_W'(TAPS);
    zero_found_c = 1'b0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (!zero_found_c && !code_c[i]) begin
        fine_c       = FINE_W'(i);
        zero_found_c = 1'b1;
      end
    end
  end

  // Next-state and result logic for the measurement sequence.
  always_comb begin
    state_d      = state_q;
    coarse_d     = coarse_q;
    therm_d      = therm_q;
    res_valid_d  = res_valid_q;
    res_coarse_d = res_coarse_q;
    res_fine_d   = res_fine_q;
    res_ovf_d    = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (start_edge_c) begin
          coarse_d = '0;
          therm_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop_edge_c) begin
          therm_d = therm_i;
          state_d = ENCODE;
        end else if (coarse_q == COARSE_MAX) begin
          res_coarse_d = COARSE_MAX;
          res_fine_d   = '0;
          res_ovf_d    = 1'b1;
          res_valid_d  = 1'b1;
          state_d      = HOLD;
        end else begin
          coarse_d = coarse_q + COARSE_W'(1);
        end
      end
      ENCODE: begin
        res_coarse_d = coarse_q;
        res_fine_d   = fine_c;
        res_ovf_d    = 1'b0;
        res_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, edge-detect and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      coarse_q     <= '0;
      therm_q      <= '0;
      res_valid_q  <= 1'b0;
      res_coarse_q <= '0;
      res_fine_q   <= '0;
      res_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_i;
      stop_q       <= stop_i;
      coarse_q     <= coarse_d;
      therm_q      <= therm_d;
      res_valid_q  <= res_valid_d;
      res_coarse_q <= res_coarse_d;
      res_fine_q   <= res_fine_d;
      res_ovf_q    <= res_ovf_d;
      busy_q       <= busy_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_coarse_o = res_coarse_q;
  assign res_fine_o   = res_fine_q;
  assign res_ovf_o    = res_ovf_q;
  assign busy_o       = busy_q;

endmodule
